// File: rtl/exe_ctrl_pkg.sv
// Shared constants for the execute-stage control slice: MIPS32 opcode and
// funct fields, ALU control codes, multiply/divide op codes and the md unit
// FSM state encoding.
package exe_ctrl_pkg;

  // Primary opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LBU   = 6'h24;
  localparam logic [5:0] OP_LHU   = 6'h25;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SH    = 6'h29;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct codes
  localparam logic [5:0] F_SLL   = 6'h00;
  localparam logic [5:0] F_SRL   = 6'h02;
  localparam logic [5:0] F_SRA   = 6'h03;
  localparam logic [5:0] F_SLLV  = 6'h04;
  localparam logic [5:0] F_SRLV  = 6'h06;
  localparam logic [5:0] F_SRAV  = 6'h07;
  localparam logic [5:0] F_JALR  = 6'h09;
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_ADD   = 6'h20;
  localparam logic [5:0] F_ADDU  = 6'h21;
  localparam logic [5:0] F_SUB   = 6'h22;
  localparam logic [5:0] F_SUBU  = 6'h23;
  localparam logic [5:0] F_AND   = 6'h24;
  localparam logic [5:0] F_OR    = 6'h25;
  localparam logic [5:0] F_XOR   = 6'h26;
  localparam logic [5:0] F_NOR   = 6'h27;
  localparam logic [5:0] F_SLT   = 6'h2A;
  localparam logic [5:0] F_SLTU  = 6'h2B;

  typedef enum logic [3:0] {
    ALU_AND  = 4'b0000,
    ALU_OR   = 4'b0001,
    ALU_XOR  = 4'b0010,
    ALU_NOR  = 4'b0011,
    ALU_ADD  = 4'b0100,
    ALU_SUB  = 4'b0101,
    ALU_SLL  = 4'b0110,
    ALU_SRL  = 4'b0111,
    ALU_SRA  = 4'b1000,
    ALU_LUI  = 4'b1001,
    ALU_SLT  = 4'b1010,
    ALU_SLTU = 4'b1011
  } alu_ctrl_t;

  typedef enum logic [1:0] {
    DST_RT = 2'b00,
    DST_RD = 2'b01,
    DST_RA = 2'b10
  } reg_dst_t;

  // md_op equals funct[1:0] of MULT/MULTU/DIV/DIVU
  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_t;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_t;

  // MULT/MULTU/DIV/DIVU occupy funct 0x18..0x1B
  function automatic logic is_md_funct(input logic [5:0] f);
    return f[5:2] == 4'b0110;
  endfunction

  // MFHI/MTHI/MFLO/MTLO occupy funct 0x10..0x13
  function automatic logic is_hilo_move(input logic [5:0] f);
    return f[5:2] == 4'b0100;
  endfunction

endpackage

// File: rtl/exe_ctrl_md_seq.sv
// md_seq: IDLE/BUSY sequencer for the multi-cycle multiply/divide unit.
// Launches one operation per E-stage MD instruction (tracked by the issued
// flag) and counts down its occupancy.
module md_seq
  import exe_ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10,
  parameter int unsigned CNT_W       = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_md_req,
  input  logic i_div,
  input  logic i_flush,
  input  logic i_e_load,
  output logic o_md_start,
  output logic o_md_busy,
  output logic o_md_done,
  output logic o_issued
);

  md_state_t        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_issued;
  logic             w_start;

  assign w_start    = (r_state == MD_IDLE) & i_md_req & ~r_issued & ~i_flush;
  assign o_md_start = w_start;
  assign o_md_busy  = (r_state == MD_BUSY);
  assign o_md_done  = (r_state == MD_BUSY) & (r_cnt == CNT_W'(1));
  assign o_issued   = r_issued;

  // FSM, busy counter and issued flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= MD_IDLE;
      r_cnt    <= '0;
      r_issued <= 1'b0;
    end else begin
      case (r_state)
        MD_IDLE: begin
          if (w_start) begin
            r_state <= MD_BUSY;
            r_cnt   <= i_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
          end
        end
        MD_BUSY: begin
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) r_state <= MD_IDLE;
        end
        default: r_state <= MD_IDLE;
      endcase
      // a new instruction entering E may issue again
      if (i_e_load)     r_issued <= 1'b0;
      else if (w_start) r_issued <= 1'b1;
    end
  end

endmodule

// File: rtl/exe_ctrl_md.sv
// exe_ctrl_md: execute-stage control for the 5-stage MIPS32 pipeline.
// Holds the D->E instruction register, decodes ALU controls from it,
// sequences the md unit via md_seq and raises HI/LO stall requests.
// Optional: define OVF_TRAP_EN to enable ovf_chk_e for ADD/SUB/ADDI.
module exe_ctrl_md
  import exe_ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_d,
  input  logic        stall_e,
  input  logic        flush_e,
  output logic [31:0] instr_e,
  output logic [3:0]  alu_ctrl_e,
  output logic        alu_src_e,
  output logic        snv_e,
  output logic [1:0]  reg_dst_e,
  output logic        md_start,
  output logic [1:0]  md_op,
  output logic        md_busy,
  output logic        md_done,
  output logic        md_stall_req,
  output logic        ovf_chk_e
);

  localparam int unsigned CNT_W =
    $clog2(((MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES) + 1);

  logic [31:0] r_instr_e;
  logic [5:0]  w_op;
  logic [5:0]  w_funct;
  logic        w_rtype;
  logic        w_md_req;
  logic        w_hilo_use;
  logic        w_e_load;
  logic        w_issued;
  alu_ctrl_t   w_alu;
  logic        w_src;
  logic        w_snv;
  reg_dst_t    w_dst;

  assign w_op       = r_instr_e[31:26];
  assign w_funct    = r_instr_e[5:0];
  assign w_rtype    = (w_op == OP_RTYPE);
  assign w_md_req   = w_rtype & is_md_funct(w_funct);
  assign w_hilo_use = w_rtype & (is_md_funct(w_funct) | is_hilo_move(w_funct));
  assign w_e_load   = flush_e | ~stall_e;

  // E register: flush beats stall
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         r_instr_e <= '0;
    else if (flush_e)  r_instr_e <= '0;
    else if (!stall_e) r_instr_e <= instr_d;
  end

  // ALU control / operand / destination decode from the E instruction
  always_comb begin
    w_alu = ALU_AND;
    w_src = 1'b0;
    w_snv = 1'b0;
    w_dst = DST_RT;
    case (w_op)
      OP_RTYPE: begin
        case (w_funct)
          F_SLL:          begin w_alu = ALU_SLL;  w_snv = 1'b1; w_dst = DST_RD; end
          F_SRL:          begin w_alu = ALU_SRL;  w_snv = 1'b1; w_dst = DST_RD; end
          F_SRA:          begin w_alu = ALU_SRA;  w_snv = 1'b1; w_dst = DST_RD; end
          F_SLLV:         begin w_alu = ALU_SLL;  w_dst = DST_RD; end
          F_SRLV:         begin w_alu = ALU_SRL;  w_dst = DST_RD; end
          F_SRAV:         begin w_alu = ALU_SRA;  w_dst = DST_RD; end
          F_ADD, F_ADDU:  begin w_alu = ALU_ADD;  w_dst = DST_RD; end
          F_SUB, F_SUBU:  begin w_alu = ALU_SUB;  w_dst = DST_RD; end
          F_AND:          begin w_alu = ALU_AND;  w_dst = DST_RD; end
          F_OR:           begin w_alu = ALU_OR;   w_dst = DST_RD; end
          F_XOR:          begin w_alu = ALU_XOR;  w_dst = DST_RD; end
          F_NOR:          begin w_alu = ALU_NOR;  w_dst = DST_RD; end
          F_SLT:          begin w_alu = ALU_SLT;  w_dst = DST_RD; end
          F_SLTU:         begin w_alu = ALU_SLTU; w_dst = DST_RD; end
          F_JALR, F_MFHI, F_MFLO: w_dst = DST_RD;
          default: ;
        endcase
      end
      OP_ADDI, OP_ADDIU: begin w_alu = ALU_ADD;  w_src = 1'b1; end
      OP_SLTI:           begin w_alu = ALU_SLT;  w_src = 1'b1; end
      OP_SLTIU:          begin w_alu = ALU_SLTU; w_src = 1'b1; end
      OP_ANDI:           begin w_alu = ALU_AND;  w_src = 1'b1; end
      OP_ORI:            begin w_alu = ALU_OR;   w_src = 1'b1; end
      OP_XORI:           begin w_alu = ALU_XOR;  w_src = 1'b1; end
      OP_LUI:            begin w_alu = ALU_LUI;  w_src = 1'b1; end
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
      OP_SB, OP_SH, OP_SW: begin w_alu = ALU_ADD; w_src = 1'b1; end
      OP_JAL:            w_dst = DST_RA;
      default: ;
    endcase
  end

  md_seq #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES),
    .CNT_W       (CNT_W)
  ) u_md_seq (
    .clk        (clk),
    .reset      (reset),
    .i_md_req   (w_md_req),
    .i_div      (w_funct[1]),
    .i_flush    (flush_e),
    .i_e_load   (w_e_load),
    .o_md_start (md_start),
    .o_md_busy  (md_busy),
    .o_md_done  (md_done),
    .o_issued   (w_issued)
  );

  assign instr_e      = r_instr_e;
  assign alu_ctrl_e   = w_alu;
  assign alu_src_e    = w_src;
  assign snv_e        = w_snv;
  assign reg_dst_e    = w_dst;
  assign md_op        = md_start ? w_funct[1:0] : '0;
  // the instruction that launched the op never stalls on its own busy
  assign md_stall_req = md_busy & w_hilo_use & ~w_issued;

`ifdef OVF_TRAP_EN
  assign ovf_chk_e = (w_rtype & ((w_funct == F_ADD) | (w_funct == F_SUB))) | (w_op == OP_ADDI);
`else
  assign ovf_chk_e = 1'b0;
`endif

endmodule

// File: tb/tb_exe_ctrl_md.sv
// Testbench for exe_ctrl_md: table-driven decode vectors through a
// scoreboard queue, plus hand-written md-unit sequences.
module tb_exe_ctrl_md;

  localparam int unsigned MC = 5;
  localparam int unsigned DC = 10;
`ifdef OVF_TRAP_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr_d;
  logic        stall_e;
  logic        flush_e;
  logic [31:0] instr_e;
  logic [3:0]  alu_ctrl_e;
  logic        alu_src_e;
  logic        snv_e;
  logic [1:0]  reg_dst_e;
  logic        md_start;
  logic [1:0]  md_op;
  logic        md_busy;
  logic        md_done;
  logic        md_stall_req;
  logic        ovf_chk_e;

  exe_ctrl_md #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .instr_d(instr_d), .stall_e(stall_e), .flush_e(flush_e),
    .instr_e(instr_e), .alu_ctrl_e(alu_ctrl_e), .alu_src_e(alu_src_e), .snv_e(snv_e),
    .reg_dst_e(reg_dst_e), .md_start(md_start), .md_op(md_op), .md_busy(md_busy),
    .md_done(md_done), .md_stall_req(md_stall_req), .ovf_chk_e(ovf_chk_e)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       nm;
    logic [31:0] instr;
    logic [3:0]  alu;
    logic        src;
    logic        snv;
    logic [1:0]  dst;
    logic        ovf;
  } vec_t;

  localparam int NV = 22;
  vec_t tbl [NV];
  vec_t sb [$];

  function automatic logic [31:0] rt(input logic [5:0] f, input logic [4:0] sh);
    return {6'h00, 5'd3, 5'd4, 5'd5, sh, f};
  endfunction

  function automatic logic [31:0] it(input logic [5:0] op);
    return {op, 5'd1, 5'd2, 16'h1234};
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_md(input string tag, input logic b, input logic d, input logic s, input logic st);
    check({tag, " busy"},  32'(md_busy),      32'(b));
    check({tag, " done"},  32'(md_done),      32'(d));
    check({tag, " start"}, 32'(md_start),     32'(s));
    check({tag, " stall"}, 32'(md_stall_req), 32'(st));
  endtask

  logic [31:0] MULT, MULTU, DIV, MFLO, ADDU, SUBU;
  vec_t e;
  int nstall, ndone;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    MULT  = rt(6'h18, 5'd0);
    MULTU = rt(6'h19, 5'd0);
    DIV   = rt(6'h1A, 5'd0);
    MFLO  = {16'h0, 5'd8, 5'd0, 6'h12};
    ADDU  = rt(6'h21, 5'd0);
    SUBU  = rt(6'h23, 5'd0);

    tbl[0]  = '{"ADDU",   rt(6'h21, 0), 4'b0100, 0, 0, 2'b01, 0};
    tbl[1]  = '{"ADD",    rt(6'h20, 0), 4'b0100, 0, 0, 2'b01, 1};
    tbl[2]  = '{"SUB",    rt(6'h22, 0), 4'b0101, 0, 0, 2'b01, 1};
    tbl[3]  = '{"SUBU",   rt(6'h23, 0), 4'b0101, 0, 0, 2'b01, 0};
    tbl[4]  = '{"SLL4",   rt(6'h00, 4), 4'b0110, 0, 1, 2'b01, 0};
    tbl[5]  = '{"SRA",    rt(6'h03, 7), 4'b1000, 0, 1, 2'b01, 0};
    tbl[6]  = '{"SRLV",   rt(6'h06, 0), 4'b0111, 0, 0, 2'b01, 0};
    tbl[7]  = '{"NOR",    rt(6'h27, 0), 4'b0011, 0, 0, 2'b01, 0};
    tbl[8]  = '{"SLTU",   rt(6'h2B, 0), 4'b1011, 0, 0, 2'b01, 0};
    tbl[9]  = '{"JALR",   rt(6'h09, 0), 4'b0000, 0, 0, 2'b01, 0};
    tbl[10] = '{"MFLO",   rt(6'h12, 0), 4'b0000, 0, 0, 2'b01, 0};
    tbl[11] = '{"MTHI",   rt(6'h11, 0), 4'b0000, 0, 0, 2'b00, 0};
    tbl[12] = '{"JR",     rt(6'h08, 0), 4'b0000, 0, 0, 2'b00, 0};
    tbl[13] = '{"LW",     it(6'h23),    4'b0100, 1, 0, 2'b00, 0};
    tbl[14] = '{"SW",     it(6'h2B),    4'b0100, 1, 0, 2'b00, 0};
    tbl[15] = '{"ADDI",   it(6'h08),    4'b0100, 1, 0, 2'b00, 1};
    tbl[16] = '{"ADDIU",  it(6'h09),    4'b0100, 1, 0, 2'b00, 0};
    tbl[17] = '{"SLTI",   it(6'h0A),    4'b1010, 1, 0, 2'b00, 0};
    tbl[18] = '{"XORI",   it(6'h0E),    4'b0010, 1, 0, 2'b00, 0};
    tbl[19] = '{"LUI",    it(6'h0F),    4'b1001, 1, 0, 2'b00, 0};
    tbl[20] = '{"JAL",    it(6'h03),    4'b0000, 0, 0, 2'b10, 0};
    tbl[21] = '{"BEQ",    it(6'h04),    4'b0000, 0, 0, 2'b00, 0};

    // reset state
    reset = 1'b1; instr_d = '0; stall_e = 1'b0; flush_e = 1'b0;
    repeat (2) @(negedge clk);
    check("rst instr_e", instr_e, 32'h0);
    check("rst alu", 32'(alu_ctrl_e), 32'h6);
    check("rst src", 32'(alu_src_e), 32'h0);
    check("rst snv", 32'(snv_e), 32'h1);
    check("rst dst", 32'(reg_dst_e), 32'h1);
    check("rst md_op", 32'(md_op), 32'h0);
    check("rst ovf", 32'(ovf_chk_e), 32'h0);
    check_md("rst", 0, 0, 0, 0);
    reset = 1'b0;

    // decode table through the scoreboard
    for (int k = 0; k < NV; k++) begin
      instr_d = tbl[k].instr;
      sb.push_back(tbl[k]);
      @(negedge clk);
      if (sb.size() == 0) begin
        check("sb empty", 32'h1, 32'h0);
      end else begin
        e = sb.pop_front();
        check({e.nm, " instr_e"}, instr_e, e.instr);
        check({e.nm, " alu"}, 32'(alu_ctrl_e), 32'(e.alu));
        check({e.nm, " src"}, 32'(alu_src_e), 32'(e.src));
        check({e.nm, " snv"}, 32'(snv_e), 32'(e.snv));
        check({e.nm, " dst"}, 32'(reg_dst_e), 32'(e.dst));
        check({e.nm, " ovf"}, 32'(ovf_chk_e), 32'(OVF_EN & e.ovf));
        check({e.nm, " md_start"}, 32'(md_start), 32'h0);
      end
    end
    instr_d = '0;
    @(negedge clk);

    // MULT: start in E cycle, busy MC cycles, done on the last
    instr_d = MULT;
    @(negedge clk);
    check_md("mult c0", 0, 0, 1, 0);
    check("mult op", 32'(md_op), 32'h0);
    instr_d = '0;
    for (int k = 1; k <= int'(MC) + 1; k++) begin
      @(negedge clk);
      check_md($sformatf("mult c%0d", k), k <= int'(MC), k == int'(MC), 0, 0);
    end

    // DIV then MFLO: MFLO stalls until the cycle after md_done
    instr_d = DIV;
    @(negedge clk);
    check_md("div c0", 0, 0, 1, 0);
    check("div op", 32'(md_op), 32'h2);
    instr_d = MFLO;
    nstall = 0;
    for (int k = 1; k <= int'(DC) + 1; k++) begin
      @(negedge clk);
      check_md($sformatf("divmflo c%0d", k), k <= int'(DC), k == int'(DC), 0, k <= int'(DC));
      if (k == int'(DC) + 1) check("mflo held", instr_e, MFLO);
      nstall += int'(md_stall_req);
      stall_e = md_stall_req;
      instr_d = '0;
    end
    check("mflo stall cycles", 32'(nstall), 32'(DC));
    @(negedge clk);
    check("mflo moved on", instr_e, 32'h0);
    stall_e = 1'b0;

    // back-to-back MULT, MULTU: one idle cycle between ops
    instr_d = MULT;
    @(negedge clk);
    check_md("b2b c0", 0, 0, 1, 0);
    instr_d = MULTU;
    for (int k = 1; k <= 2 * int'(MC) + 2; k++) begin
      @(negedge clk);
      if (k <= int'(MC))
        check_md($sformatf("b2b c%0d", k), 1, k == int'(MC), 0, 1);
      else if (k == int'(MC) + 1) begin
        check_md($sformatf("b2b c%0d", k), 0, 0, 1, 0);
        check("b2b op", 32'(md_op), 32'h1);
      end else
        check_md($sformatf("b2b c%0d", k), k <= 2 * int'(MC) + 1, k == 2 * int'(MC) + 1, 0, 0);
      stall_e = md_stall_req;
      if (k >= 1) instr_d = '0;
    end
    stall_e = 1'b0;

    // issued MD op held in E by an external stall: no restart, no self-stall
    instr_d = MULT;
    @(negedge clk);
    check_md("iss c0", 0, 0, 1, 0);
    stall_e = 1'b1;
    @(negedge clk);
    check("iss held", instr_e, MULT);
    check_md("iss c1", 1, 0, 0, 0);
    stall_e = 1'b0; instr_d = '0;
    for (int k = 2; k <= int'(MC) + 1; k++) begin
      @(negedge clk);
      check_md($sformatf("iss c%0d", k), k <= int'(MC), k == int'(MC), 0, 0);
    end

    // flush suppresses launch; flush while busy does not abort
    instr_d = MULT;
    @(negedge clk);
    flush_e = 1'b1;
    #1;
    check("flush blocks start", 32'(md_start), 32'h0);
    @(negedge clk);
    check("flush killed mult", instr_e, 32'h0);
    check("flush no busy", 32'(md_busy), 32'h0);
    flush_e = 1'b0;
    @(negedge clk);
    check_md("fb c0", 0, 0, 1, 0);
    instr_d = '0;
    for (int k = 1; k <= int'(MC) + 1; k++) begin
      @(negedge clk);
      check_md($sformatf("fb c%0d", k), k <= int'(MC), k == int'(MC), 0, 0);
      flush_e = (k == 1);
    end
    flush_e = 1'b0;

    // stall alone holds, flush with stall loads a bubble
    instr_d = ADDU;
    @(negedge clk);
    check("load addu", instr_e, ADDU);
    stall_e = 1'b1; instr_d = SUBU;
    @(negedge clk);
    check("stall holds", instr_e, ADDU);
    flush_e = 1'b1;
    @(negedge clk);
    check("flush over stall", instr_e, 32'h0);
    flush_e = 1'b0; stall_e = 1'b0; instr_d = '0;

    // reset mid-BUSY: idle at once, no done pulse
    instr_d = DIV;
    @(negedge clk);
    check_md("rdiv c0", 0, 0, 1, 0);
    instr_d = '0;
    repeat (3) @(negedge clk);
    check("rdiv busy", 32'(md_busy), 32'h1);
    reset = 1'b1;
    #1;
    check_md("rdiv rst", 0, 0, 0, 0);
    check("rdiv instr_e", instr_e, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    ndone = 0;
    for (int k = 0; k < int'(DC) + 2; k++) begin
      @(negedge clk);
      ndone += int'(md_done) + int'(md_busy);
    end
    check("rdiv no done", 32'(ndone), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
